// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage with gap-tolerant streaming, flush,
// a selectable twiddle stage and optional 1-bit output scaling.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   valid_i, data_in_*   input sample strobe and complex sample (DW bits per component)
//   flush_i              drive the stage with zero samples while busy_o, valid_i low
//   tw_addr_o            twiddle index n for the external ROM (combinational)
//   tw_r_i, tw_i_i       twiddle returned for tw_addr_o (Q1.(TW_W-1))
//   valid_o, data_out_*  registered output strobe and complex result (OW bits per component)
//   busy_o               stage holds a partial frame or undelivered differences
module sdf_r2_stage #(
  parameter int unsigned DW         = 16,
  parameter int unsigned LOG2_DEPTH = 1,
  parameter int unsigned TW_MODE    = 1,
  parameter int unsigned TW_W       = 16,
  parameter int unsigned SCALE      = 0,
  localparam int unsigned OW        = (SCALE != 0) ? DW : DW + 1,
  localparam int unsigned AW        = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_in_r,
  input  logic [DW-1:0] data_in_i,
  input  logic          flush_i,
  output logic [AW-1:0] tw_addr_o,
  input  logic [TW_W-1:0] tw_r_i,
  input  logic [TW_W-1:0] tw_i_i,
  output logic          valid_o,
  output logic [OW-1:0] data_out_r,
  output logic [OW-1:0] data_out_i,
  output logic          busy_o
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;
  localparam int unsigned EW    = DW + 1;

  logic                 r_valid, r_flush;
  logic signed [DW-1:0] r_in_r, r_in_i;
  logic [CW-1:0]        r_cnt;
  logic                 r_pend;
  // Frame since the last wrap contains at least one real sample.
  logic                 r_real;
  logic signed [EW-1:0] r_dly_r [DEPTH];
  logic signed [EW-1:0] r_dly_i [DEPTH];
  logic                 r_vout;
  logic [OW-1:0]        r_out_r, r_out_i;

  logic                 w_step, w_phase, w_mid, w_end, w_empty_frame;
  logic signed [EW-1:0] w_a_r, w_a_i, w_b_r, w_b_i;
  logic signed [EW-1:0] w_sum_r, w_sum_i, w_diff_r, w_diff_i;
  logic signed [EW-1:0] w_tw_r, w_tw_i, w_res_r, w_res_i;
  logic [OW-1:0]        w_o_r, w_o_i;
  logic [AW-1:0]        w_n;

  assign busy_o  = (r_cnt != '0) | r_pend;
  assign w_step  = r_valid | (r_flush & busy_o);
  assign w_phase = r_cnt[CW-1];
  assign w_mid   = (r_cnt == CW'(DEPTH - 1));
  assign w_end   = &r_cnt;
  // A frame made only of flush padding exists solely to drain differences; once they are
  // out, return the counter to zero instead of running an all-zero second half.
  assign w_empty_frame = w_mid & ~r_real & ~r_valid;

  assign w_a_r = r_valid ? {r_in_r[DW-1], r_in_r} : '0;
  assign w_a_i = r_valid ? {r_in_i[DW-1], r_in_i} : '0;
  assign w_b_r = r_dly_r[DEPTH-1];
  assign w_b_i = r_dly_i[DEPTH-1];

  assign w_sum_r  = w_b_r + w_a_r;
  assign w_sum_i  = w_b_i + w_a_i;
  assign w_diff_r = w_b_r - w_a_r;
  assign w_diff_i = w_b_i - w_a_i;

  if (LOG2_DEPTH > 0) begin : g_addr
    assign w_n = r_cnt[AW-1:0];
  end else begin : g_addr0
    assign w_n = '0;
  end
  assign tw_addr_o = w_n;

  if (TW_MODE == 2) begin : g_tw_gen
    localparam int unsigned PW = EW + TW_W + 1;
    logic signed [PW-1:0] w_br, w_bi, w_twr, w_twi, w_pr, w_pi, w_sr, w_si;

    function automatic logic signed [EW-1:0] sat(input logic signed [PW-1:0] x);
      if ((&x[PW-1:EW-1]) | ~(|x[PW-1:EW-1])) return x[EW-1:0];
      return x[PW-1] ? {1'b1, {(EW-1){1'b0}}} : {1'b0, {(EW-1){1'b1}}};
    endfunction

    assign w_br  = PW'(w_b_r);
    assign w_bi  = PW'(w_b_i);
    assign w_twr = PW'($signed(tw_r_i));
    assign w_twi = PW'($signed(tw_i_i));
    assign w_pr  = w_br * w_twr - w_bi * w_twi;
    assign w_pi  = w_br * w_twi + w_bi * w_twr;
    assign w_sr  = (w_pr + (PW'(1) <<< (TW_W - 2))) >>> (TW_W - 1);
    assign w_si  = (w_pi + (PW'(1) <<< (TW_W - 2))) >>> (TW_W - 1);
    assign w_tw_r = sat(w_sr);
    assign w_tw_i = sat(w_si);
  end else begin : g_tw_fixed
    logic w_tw_unused;
    assign w_tw_unused = ^{tw_r_i, tw_i_i};
    if (TW_MODE == 1) begin : g_mj
      // Multiply by -j at n == 1: (r, i) -> (i, -r).
      assign w_tw_r = (w_n == AW'(1)) ? w_b_i : w_b_r;
      assign w_tw_i = (w_n == AW'(1)) ? -w_b_r : w_b_i;
    end else begin : g_id
      assign w_tw_r = w_b_r;
      assign w_tw_i = w_b_i;
    end
  end

  assign w_res_r = w_phase ? w_sum_r : w_tw_r;
  assign w_res_i = w_phase ? w_sum_i : w_tw_i;

  if (SCALE != 0) begin : g_scale
    logic signed [EW:0] w_sc_r, w_sc_i;
    logic               w_scale_unused;
    assign w_sc_r = {w_res_r[EW-1], w_res_r} + (EW + 1)'(1);
    assign w_sc_i = {w_res_i[EW-1], w_res_i} + (EW + 1)'(1);
    assign w_o_r  = w_sc_r[DW:1];
    assign w_o_i  = w_sc_i[DW:1];
    assign w_scale_unused = ^{w_sc_r[EW], w_sc_r[0], w_sc_i[EW], w_sc_i[0]};
  end else begin : g_noscale
    assign w_o_r = w_res_r;
    assign w_o_i = w_res_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_in_r  <= '0;
      r_in_i  <= '0;
    end else begin
      r_valid <= valid_i;
      r_flush <= flush_i;
      r_in_r  <= data_in_r;
      r_in_i  <= data_in_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_real  <= 1'b0;
      r_vout  <= 1'b0;
      r_out_r <= '0;
      r_out_i <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_dly_r[k] <= '0;
        r_dly_i[k] <= '0;
      end
    end else if (w_step) begin
      r_cnt  <= w_empty_frame ? '0 : r_cnt + CW'(1);
      r_real <= w_end ? 1'b0 : (r_real | r_valid);
      if (w_end) begin
        r_pend <= 1'b1;
      end else if (w_mid) begin
        r_pend <= 1'b0;
      end
      for (int k = int'(DEPTH) - 1; k > 0; k--) begin
        r_dly_r[k] <= r_dly_r[k-1];
        r_dly_i[k] <= r_dly_i[k-1];
      end
      r_dly_r[0] <= w_phase ? w_diff_r : w_a_r;
      r_dly_i[0] <= w_phase ? w_diff_i : w_a_i;
      r_vout     <= w_phase | r_pend;
      r_out_r    <= w_o_r;
      r_out_i    <= w_o_i;
    end else begin
      r_vout <= 1'b0;
    end
  end

  assign valid_o    = r_vout;
  assign data_out_r = r_out_r;
  assign data_out_i = r_out_i;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Scoreboard bench for sdf_r2_stage: three instances (trivial -j twiddle, general ROM
// twiddle with saturation, depth-1 with scaling) share one randomized input stream.
// A frame-level reference model pushes expected outputs; a negedge monitor pops them.
module tb_sdf_r2_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               valid_i, flush_i;
  logic signed [15:0] din_r, din_i;

  logic [0:0]         a_addr_unused, c_addr_unused;
  logic [1:0]         b_addr;
  logic               a_vo, b_vo, c_vo, a_busy, b_busy, c_busy;
  logic signed [16:0] a_or, a_oi, b_or, b_oi;
  logic signed [15:0] c_or, c_oi;
  logic signed [15:0] rom_r [4];
  logic signed [15:0] rom_i [4];

  sdf_r2_stage #(.DW(16), .LOG2_DEPTH(1), .TW_MODE(1), .TW_W(16), .SCALE(0)) u_a (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(din_r), .data_in_i(din_i),
    .flush_i(flush_i), .tw_addr_o(a_addr_unused), .tw_r_i(16'd0), .tw_i_i(16'd0),
    .valid_o(a_vo), .data_out_r(a_or), .data_out_i(a_oi), .busy_o(a_busy));

  sdf_r2_stage #(.DW(16), .LOG2_DEPTH(2), .TW_MODE(2), .TW_W(16), .SCALE(0)) u_b (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(din_r), .data_in_i(din_i),
    .flush_i(flush_i), .tw_addr_o(b_addr), .tw_r_i(rom_r[b_addr]), .tw_i_i(rom_i[b_addr]),
    .valid_o(b_vo), .data_out_r(b_or), .data_out_i(b_oi), .busy_o(b_busy));

  sdf_r2_stage #(.DW(16), .LOG2_DEPTH(0), .TW_MODE(0), .TW_W(16), .SCALE(1)) u_c (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(din_r), .data_in_i(din_i),
    .flush_i(flush_i), .tw_addr_o(c_addr_unused), .tw_r_i(16'd0), .tw_i_i(16'd0),
    .valid_o(c_vo), .data_out_r(c_or), .data_out_i(c_oi), .busy_o(c_busy));

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_idle = 1'b0;
  logic chk_rst  = 1'b0;

  // Reference state: samples of the current frame, expected outputs, directed values for u_a.
  int fr_r [3][$];
  int fr_i [3][$];
  int exp_r [3][$];
  int exp_i [3][$];
  int dir_r [$];
  int dir_i [$];

  function automatic int depth(input int id);
    return (id == 0) ? 2 : (id == 1) ? 4 : 1;
  endfunction

  function automatic int fin(input int id, input int x);
    return (id == 2) ? ((x + 1) >>> 1) : x;
  endfunction

  function automatic int sat17(input longint x);
    if (x > 65535) return 65535;
    if (x < -65536) return -65536;
    return int'(x);
  endfunction

  // Difference times W_(2*DEPTH)^k, as each instance implements it.
  task automatic twid(input int id, input int k, input int dr, input int di,
                      output int tr, output int ti);
    longint pr, pi;
    tr = dr;
    ti = di;
    if (id == 0 && k == 1) begin
      tr = di;
      ti = -dr;
    end else if (id == 1) begin
      pr = longint'(dr) * longint'(rom_r[k]) - longint'(di) * longint'(rom_i[k]);
      pi = longint'(dr) * longint'(rom_i[k]) + longint'(di) * longint'(rom_r[k]);
      tr = sat17((pr + 16384) >>> 15);
      ti = sat17((pi + 16384) >>> 15);
    end
  endtask

  task automatic model_in(input int id, input int xr, input int xi);
    int d, sz, tr, ti;
    d = depth(id);
    fr_r[id].push_back(xr);
    fr_i[id].push_back(xi);
    sz = fr_r[id].size();
    if (sz > d) begin
      exp_r[id].push_back(fin(id, fr_r[id][sz-1-d] + xr));
      exp_i[id].push_back(fin(id, fr_i[id][sz-1-d] + xi));
    end
    if (sz == 2 * d) begin
      for (int k = 0; k < d; k++) begin
        twid(id, k, fr_r[id][k] - fr_r[id][k+d], fr_i[id][k] - fr_i[id][k+d], tr, ti);
        exp_r[id].push_back(fin(id, tr));
        exp_i[id].push_back(fin(id, ti));
      end
      fr_r[id].delete();
      fr_i[id].delete();
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic pop_cmp(input int id, input int ar, input int ai);
    int er, ei;
    if (exp_r[id].size() == 0) begin
      check($sformatf("dut%0d_unexpected_valid", id), 1, 0);
    end else begin
      er = exp_r[id].pop_front();
      ei = exp_i[id].pop_front();
      check($sformatf("dut%0d_re", id), ar, er);
      check($sformatf("dut%0d_im", id), ai, ei);
    end
    if (id == 0 && dir_r.size() != 0) begin
      er = dir_r.pop_front();
      ei = dir_i.pop_front();
      check("directed_re", ar, er);
      check("directed_im", ai, ei);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (chk_rst) begin
        check("rst_valid", int'({a_vo, b_vo, c_vo}), 0);
        check("rst_busy", int'({a_busy, b_busy, c_busy}), 0);
        check("rst_data_a", int'(a_or | a_oi), 0);
        check("rst_data_b", int'(b_or | b_oi), 0);
        check("rst_data_c", int'(c_or | c_oi), 0);
      end
    end else begin
      if (a_vo) pop_cmp(0, a_or, a_oi);
      if (b_vo) pop_cmp(1, b_or, b_oi);
      if (c_vo) pop_cmp(2, c_or, c_oi);
      if (chk_idle) begin
        check("idle_busy", int'({a_busy, b_busy, c_busy}), 0);
        check("idle_valid", int'({a_vo, b_vo, c_vo}), 0);
        for (int id = 0; id < 3; id++) begin
          check($sformatf("dut%0d_missing_outputs", id), exp_r[id].size(), 0);
        end
        check("directed_missing", dir_r.size(), 0);
      end
    end
  end

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic send(input int xr, input int xi, input logic fl);
    @(negedge clk);
    valid_i = 1'b1;
    flush_i = fl;
    din_r   = 16'(xr);
    din_i   = 16'(xi);
    for (int id = 0; id < 3; id++) model_in(id, xr, xi);
  endtask

  // Idle cycles carry random data that the stage must ignore.
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b0;
      din_r   = 16'($urandom);
      din_i   = 16'($urandom);
    end
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1 chk_idle = 1'b1;
    @(posedge clk);
    #1 chk_idle = 1'b0;
  endtask

  task automatic drain();
    for (int id = 0; id < 3; id++) begin
      while (fr_r[id].size() != 0) model_in(id, 0, 0);
    end
    repeat (24) begin
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b1;
    end
    gap(3);
    idle_check();
  endtask

  task automatic push_dir(input int r, input int i);
    dir_r.push_back(r);
    dir_i.push_back(i);
  endtask

  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      fr_r[id].delete();
      fr_i[id].delete();
      exp_r[id].delete();
      exp_i[id].delete();
    end
    dir_r.delete();
    dir_i.delete();
    @(posedge clk);
    #1 chk_rst = 1'b1;
    @(posedge clk);
    #1 chk_rst = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_check();
  endtask

  initial begin
    valid_i = 1'b0;
    flush_i = 1'b0;
    din_r   = '0;
    din_i   = '0;
    rst     = 1'b1;
    rom_r[0] = -16'sd32768;
    rom_i[0] = -16'sd32768;
    for (int k = 1; k < 4; k++) begin
      rom_r[k] = 16'($urandom);
      rom_i[k] = 16'($urandom);
    end
    reset_all();

    // T1: gapless 1,2,3,4 then flush.
    push_dir(4, 0); push_dir(6, 0); push_dir(-2, 0); push_dir(0, 2);
    for (int x = 1; x <= 4; x++) send(x, 0, 1'b0);
    drain();

    // T2: same frame with gaps of 0..3 cycles.
    push_dir(4, 0); push_dir(6, 0); push_dir(-2, 0); push_dir(0, 2);
    for (int x = 1; x <= 4; x++) begin
      gap($urandom_range(0, 3));
      send(x, 0, 1'b0);
    end
    gap($urandom_range(0, 3));
    drain();

    // T3: extreme difference against tw=(-1,-1) forces saturation in the general twiddle.
    send(-32768, -32768, 1'b0);
    for (int k = 1; k < 4; k++) send(rnd16(), rnd16(), 1'b0);
    send(32767, 32767, 1'b0);
    for (int k = 5; k < 8; k++) send(rnd16(), rnd16(), 1'b0);
    drain();

    // Random stream with gaps; flush_i raised alongside valid_i must be ignored.
    for (int i = 0; i < 300; i++) begin
      gap(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      send(rnd16(), rnd16(), $urandom_range(0, 4) == 0);
      if (i % 75 == 74) drain();
    end
    drain();

    // T4: scaled depth-1 stage on a full-scale pair.
    send(32767, 32767, 1'b0);
    send(32767, 32767, 1'b0);
    drain();

    // T5: reset after three samples, then a fresh frame.
    send(5, 0, 1'b0);
    send(6, 0, 1'b0);
    send(7, 0, 1'b0);
    gap(6);
    reset_all();
    push_dir(12, 0); push_dir(14, 0); push_dir(-2, 0); push_dir(0, 2);
    for (int x = 5; x <= 8; x++) send(x, 0, 1'b0);
    drain();

    // T6: flush with nothing pending produces nothing.
    repeat (6) begin
      @(negedge clk);
      valid_i = 1'b0;
      flush_i = 1'b1;
    end
    gap(3);
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
